// File: rtl/mean_filter_3x3_param.sv
// 3x3 luma smoothing filter (bypass / box /9 / Gaussian /16 / 8-neighbour /8) with internal line buffers.
// Define MEAN_FILTER_ROUND_EN for round-half-up results; otherwise results are truncated.
module mean_filter_3x3_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned COL_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_Y,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y
);
    localparam int unsigned ROW_W  = DATA_W + 2;
    localparam int unsigned SUM_W  = DATA_W + 4;
    localparam int unsigned PROD_W = DATA_W + 18;
    localparam int unsigned AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned MAX_V  = (1 << DATA_W) - 1;
    localparam int unsigned BOX_K  = 7282;
`ifdef MEAN_FILTER_ROUND_EN
    localparam int unsigned RND16 = 32768;
    localparam int unsigned RND4  = 8;
    localparam int unsigned RND3  = 4;
`else
    localparam int unsigned RND16 = 0;
    localparam int unsigned RND4  = 0;
    localparam int unsigned RND3  = 0;
`endif
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [1:0] MODE_BOX = 2'd1;
    localparam logic [1:0] MODE_GAU = 2'd2;
    localparam logic [1:0] MODE_NB8 = 2'd3;

    logic              vsync_q, href_q;
    logic              vsync_rise, href_rise, href_fall, strobe;
    logic [1:0]        mode_r;
    logic [COL_W-1:0]  col, col_eff, col_nxt;
    logic              col_sat;
    logic [15:0]       row;
    logic [AW-1:0]     lb_addr;
    logic              border_c;

    assign vsync_rise = per_frame_vsync & ~vsync_q;
    assign href_rise  = per_frame_href & ~href_q;
    assign href_fall  = ~per_frame_href & href_q;
    assign strobe     = per_frame_clken & per_frame_href;

    // A pixel arriving on the href rising edge is column 0 even though col clears on that same edge.
    assign col_eff  = href_rise ? '0 : col;
    assign col_sat  = (col_eff == COL_LAST);
    assign col_nxt  = col_sat ? COL_LAST : col_eff + COL_W'(1);
    assign lb_addr  = AW'(col_eff);
    assign border_c = (row < 16'd2) | (col_eff < COL_W'(2)) | col_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            mode_r  <= 2'd0;
            col     <= '0;
            row     <= '0;
        end else begin
            vsync_q <= per_frame_vsync;
            href_q  <= per_frame_href;
            if (vsync_rise) mode_r <= mode;
            if (strobe) col <= col_nxt;
            else        col <= col_eff;
            if (vsync_rise)                      row <= '0;
            else if (href_fall && row != 16'hFFFF) row <= row + 16'd1;
        end
    end

    // Line buffers: read-before-write, lb1 holds the line before lb0.
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0[lb_addr];
    assign lb1_rd = lb1[lb_addr];

    always_ff @(posedge clk) begin
        if (strobe) begin
            lb0[lb_addr] <= per_img_Y;
            lb1[lb_addr] <= lb0[lb_addr];
        end
    end

    logic [DATA_W-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic              border_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
            border_r <= 1'b0;
        end else if (strobe) begin
            p11 <= p12; p12 <= p13; p13 <= lb1_rd;
            p21 <= p22; p22 <= p23; p23 <= lb0_rd;
            p31 <= p32; p32 <= p33; p33 <= per_img_Y;
            border_r <= border_c;
        end
    end

    function automatic logic [ROW_W-1:0] row_sum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c,
                                                 input logic dbl, input logic zero_mid);
        logic [ROW_W-1:0] mid;
        mid = zero_mid ? '0 : (dbl ? (ROW_W'(b) << 1) : ROW_W'(b));
        return ROW_W'(a) + mid + ROW_W'(c);
    endfunction

    // S1: row sums; Gaussian rows are 1-2-1 here and the middle row is doubled in S2.
    logic [ROW_W-1:0]  r1_c, r2_c, r3_c, r1_s1, r2_s1, r3_s1;
    logic [1:0]        mode_s1, mode_s2;
    logic              border_s1, border_s2;
    logic [DATA_W-1:0] p22_s1, p22_s2;
    logic              gau_c;

    assign gau_c = (mode_r == MODE_GAU);
    assign r1_c  = row_sum(p11, p12, p13, gau_c, 1'b0);
    assign r2_c  = row_sum(p21, p22, p23, gau_c, mode_r == MODE_NB8);
    assign r3_c  = row_sum(p31, p32, p33, gau_c, 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_s1     <= '0;
            r2_s1     <= '0;
            r3_s1     <= '0;
            mode_s1   <= 2'd0;
            border_s1 <= 1'b0;
            p22_s1    <= '0;
        end else begin
            r1_s1     <= r1_c;
            r2_s1     <= r2_c;
            r3_s1     <= r3_c;
            mode_s1   <= mode_r;
            border_s1 <= border_r;
            p22_s1    <= p22;
        end
    end

    // S2: total weighted sum.
    logic [SUM_W-1:0] sum_c, sum_s2;
    logic [SUM_W-1:0] mid_c;

    assign mid_c = (mode_s1 == MODE_GAU) ? (SUM_W'(r2_s1) << 1) : SUM_W'(r2_s1);
    assign sum_c = SUM_W'(r1_s1) + mid_c + SUM_W'(r3_s1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_s2    <= '0;
            mode_s2   <= 2'd0;
            border_s2 <= 1'b0;
            p22_s2    <= '0;
        end else begin
            sum_s2    <= sum_c;
            mode_s2   <= mode_s1;
            border_s2 <= border_s1;
            p22_s2    <= p22_s1;
        end
    end

    // S3: scale, clamp and select.
    logic [PROD_W-1:0] res_w;
    logic [DATA_W-1:0] res_c;

    always_comb begin
        res_w = PROD_W'(p22_s2);
        if (!border_s2) begin
            case (mode_s2)
                MODE_BOX: res_w = (PROD_W'(sum_s2) * PROD_W'(BOX_K) + PROD_W'(RND16)) >> 16;
                MODE_GAU: res_w = (PROD_W'(sum_s2) + PROD_W'(RND4)) >> 4;
                MODE_NB8: res_w = (PROD_W'(sum_s2) + PROD_W'(RND3)) >> 3;
                default:  res_w = PROD_W'(p22_s2);
            endcase
        end
        res_c = (res_w > PROD_W'(MAX_V)) ? DATA_W'(MAX_V) : DATA_W'(res_w);
    end

    logic [2:0] sync_d [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) sync_d[i] <= '0;
            post_img_Y <= '0;
        end else begin
            sync_d[0] <= {per_frame_vsync, per_frame_href, per_frame_clken};
            for (int i = 1; i < 4; i++) sync_d[i] <= sync_d[i-1];
            post_img_Y <= sync_d[2][1] ? res_c : '0;
        end
    end

    assign post_frame_vsync = sync_d[3][2];
    assign post_frame_href  = sync_d[3][1];
    assign post_frame_clken = sync_d[3][0];

endmodule

// File: tb/tb_mean_filter_3x3_param.sv
// Randomised bench for mean_filter_3x3_param against a frame-level behavioural model.
module tb_mean_filter_3x3_param;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IMG_W  = 80;
    localparam int unsigned COL_W  = 7;
    localparam int MAXV = (1 << DATA_W) - 1;
`ifdef MEAN_FILTER_ROUND_EN
    localparam int RND16 = 32768;
    localparam int RND4  = 8;
    localparam int RND3  = 4;
`else
    localparam int RND16 = 0;
    localparam int RND4  = 0;
    localparam int RND3  = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        mode = 2'd0;
    logic              per_frame_vsync = 1'b0;
    logic              per_frame_href = 1'b0;
    logic              per_frame_clken = 1'b0;
    logic [DATA_W-1:0] per_img_Y = '0;
    logic              post_frame_vsync, post_frame_href, post_frame_clken;
    logic [DATA_W-1:0] post_img_Y;

    mean_filter_3x3_param #(.DATA_W(DATA_W), .IMG_W(IMG_W), .COL_W(COL_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mode             (mode),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit vs;
        bit hr;
        bit ck;
        int y;
        bit y_ok;
    } exp_t;

    // Model state: per-column history of the last two pixels written, the 3x3 neighbourhood, frame position.
    int   h0 [IMG_W];
    int   h1 [IMG_W];
    bit   h0_ok [IMG_W];
    bit   h1_ok [IMG_W];
    int   win [3][3];
    bit   wok [3][3];
    bit   m_border;
    int   m_mode, m_col, m_row;
    bit   m_vs_q, m_hr_q;
    exp_t m_pipe [4];

    task automatic model_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                win[r][c] = 0;
                wok[r][c] = 1'b1;
            end
        m_border = 1'b0;
        m_mode = 0; m_col = 0; m_row = 0;
        m_vs_q = 1'b0; m_hr_q = 1'b0;
        for (int i = 0; i < 4; i++) m_pipe[i] = '{0, 0, 0, 0, 1'b1};
    endtask

    task automatic model_value(output int y, output bit ok);
        int wt, sum;
        if (m_border || m_mode == 0) begin
            y = win[1][1];
            ok = wok[1][1];
        end else begin
            sum = 0;
            ok = 1'b1;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    if (m_mode == 2)      wt = (r == 1 ? 2 : 1) * (c == 1 ? 2 : 1);
                    else if (m_mode == 3) wt = (r == 1 && c == 1) ? 0 : 1;
                    else                  wt = 1;
                    sum += wt * win[r][c];
                    if (wt != 0 && !wok[r][c]) ok = 1'b0;
                end
            if (m_mode == 1)      y = (sum * 7282 + RND16) / 65536;
            else if (m_mode == 2) y = (sum + RND4) / 16;
            else                  y = (sum + RND3) / 8;
            if (y > MAXV) y = MAXV;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                bit vs, hr, ck, vs_rise, hr_rise, hr_fall;
                int ce, a;
                exp_t e;
                vs = per_frame_vsync; hr = per_frame_href; ck = per_frame_clken;
                vs_rise = vs && !m_vs_q;
                hr_rise = hr && !m_hr_q;
                hr_fall = !hr && m_hr_q;
                if (vs_rise) m_mode = int'(mode);
                ce = hr_rise ? 0 : m_col;
                if (hr && ck) begin
                    a = ce;
                    for (int r = 0; r < 3; r++) begin
                        win[r][0] = win[r][1]; wok[r][0] = wok[r][1];
                        win[r][1] = win[r][2]; wok[r][1] = wok[r][2];
                    end
                    win[0][2] = h1[a]; wok[0][2] = h1_ok[a];
                    win[1][2] = h0[a]; wok[1][2] = h0_ok[a];
                    win[2][2] = int'(per_img_Y); wok[2][2] = 1'b1;
                    h1[a] = h0[a]; h1_ok[a] = h0_ok[a];
                    h0[a] = int'(per_img_Y); h0_ok[a] = 1'b1;
                    m_border = (m_row < 2) || (ce < 2) || (ce == IMG_W - 1);
                    m_col = (ce + 1 > IMG_W - 1) ? IMG_W - 1 : ce + 1;
                end else begin
                    m_col = ce;
                end
                if (vs_rise)                    m_row = 0;
                else if (hr_fall && m_row < 65535) m_row++;
                m_vs_q = vs;
                m_hr_q = hr;
                e.vs = vs; e.hr = hr; e.ck = ck;
                if (hr) model_value(e.y, e.y_ok);
                else begin e.y = 0; e.y_ok = 1'b1; end
                for (int i = 3; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = e;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("vsync", int'(post_frame_vsync), int'(m_pipe[3].vs));
            check("href",  int'(post_frame_href),  int'(m_pipe[3].hr));
            check("clken", int'(post_frame_clken), int'(m_pipe[3].ck));
            if (m_pipe[3].y_ok) check("pixel", int'(post_img_Y), m_pipe[3].y);
            check("addr_in_range", (int'(dut.lb_addr) < IMG_W) ? 1 : 0, 1);
        end
    end

    task automatic drive(input bit vs, input bit hr, input bit ck, input int y);
        @(posedge clk);
        #1;
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ck;
        per_img_Y       = DATA_W'(y);
    endtask

    function automatic int pixel(input int pat, input int r, input int c);
        case (pat)
            0:       return 100;
            1:       return (r == 3 && c == 5) ? 255 : 0;
            2:       return (r == 3 && c == 5) ? 0 : 80;
            default: return int'($urandom_range(0, MAXV));
        endcase
    endfunction

    task automatic run_frame(input int w, input int h, input int md, input int pat,
                             input int switch_md, input int rst_line, input bit gappy);
        int n;
        bit ck;
        mode = 2'(md);
        repeat (2) drive(1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        for (int r = 0; r < h; r++) begin
            if (r == rst_line) begin
                rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            if (switch_md >= 0 && r == h / 2) mode = 2'(switch_md);
            n = 0;
            while (n < w) begin
                ck = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
                drive(0, 1, ck, ck ? pixel(pat, r, n) : int'($urandom_range(0, MAXV)));
                if (ck) n++;
            end
            drive(0, 0, 0, 0);
            drive(0, 0, 1, int'($urandom_range(0, MAXV)));
            repeat (4) drive(0, 0, 0, 0);
        end
        repeat (6) drive(0, 0, 0, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(64, 8, 1, 0, -1, -1, 1'b0);
        run_frame(64, 8, 1, 0, -1, -1, 1'b1);
        run_frame(64, 8, 1, 1, -1, -1, 1'b0);
        run_frame(64, 8, 2, 1, -1, -1, 1'b1);
        run_frame(64, 8, 3, 2, -1, -1, 1'b0);
        run_frame(64, 8, 1, 2, -1, -1, 1'b1);
        run_frame(64, 8, 1, 3, 0, -1, 1'b1);
        run_frame(64, 8, 0, 3, -1, -1, 1'b1);
        run_frame(IMG_W + 10, 5, 1, 3, -1, -1, 1'b1);
        run_frame(64, 8, 2, 3, -1, 3, 1'b1);
        run_frame(64, 8, 2, 3, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_frame(int'($urandom_range(8, IMG_W + 4)), int'($urandom_range(4, 7)),
                      int'($urandom_range(0, 3)), 3, -1, -1, 1'($urandom_range(0, 1)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mean_filter_3x3_param.md
Name: mean_filter_3x3_param

Overview:
Parametrised successor to the fixed 8-bit neighbourhood mean filter. It has internal line buffers, so no external 3x3 matrix generator is needed. The window is centred on the pixel one line and one column behind the input.
- Modes, selectable at run time: box mean /9, Gaussian 1-2-1 /16, 8-neighbour mean /8, bypass.
- Border pixels are passed through unfiltered.
- Sits in the luma path between the YCbCr converter and the Sobel/binarisation blocks; uses the same vsync/href/clken stream interface.

Parameters:
- DATA_W, 8, pixel bit width (4..12).
- IMG_W, 640, maximum active pixels per line; sets line-buffer depth.
- COL_W, 10, column counter width; must satisfy 2^COL_W >= IMG_W.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- mode  in  2  0 bypass, 1 box /9, 2 Gaussian /16, 3 8-neighbour /8
- per_frame_vsync  in  1  input vsync
- per_frame_href  in  1  input line valid
- per_frame_clken  in  1  input pixel strobe
- per_img_Y  in  DATA_W  input pixel
- post_frame_vsync  out  1  vsync delayed 4 clk
- post_frame_href  out  1  href delayed 4 clk
- post_frame_clken  out  1  clken delayed 4 clk
- post_img_Y  out  DATA_W  filtered pixel; 0 when post_frame_href low

Behaviour:
Interface and reset
- Reset rst_n, asynchronous, active-low; clock clk.
- On reset, all registers, counters, sync pipes and outputs go to 0, and mode_r = 0 (bypass).
- Line-buffer RAM contents are not reset.

Mode sampling
- mode_r samples mode on the rising edge of per_frame_vsync only, so a mid-frame change takes effect from the next frame.

Counters
- col: cleared on the href rising edge; increments on each clken while href is high; saturates at IMG_W-1.
- row: cleared on the vsync rising edge; increments on each href falling edge; saturates at 2^16-1.

Line buffers and window
- Two RAMs, depth IMG_W, addressed by col.
- On clken && href: read lb0[col] and lb1[col]; write lb0[col] <= per_img_Y and lb1[col] <= old lb0[col]. This is read-before-write in the same cycle.
- Window columns shift left on the same strobe; new column is {lb1 out, lb0 out, per_img_Y}, with p33 = current pixel.
- The window register adds 1 clk to the sync path.

Border rule
- If row < 2, col < 2, or col saturated (line longer than IMG_W), the output is p22 unfiltered regardless of mode.
- The border flag travels with the pipeline.

Arithmetic pipeline (3 clk, free-running, not gated by clken)
- S1: row sums r1, r2, r3, width DATA_W+2.
  - Gaussian uses weights 1-2-1 / 2-4-2 / 1-2-1.
  - Mode 3 zeroes p22.
- S2: total sum, width DATA_W+4.
- S3: scale, clamp and select.
  - Box: (sum*7282 + RND16) >> 16.
  - Gaussian: (sum + RND4) >> 4.
  - 8-neighbour: (sum + RND3) >> 3.
  - Bypass/border: p22 delayed to S3.
- All results are clamped to 2^DATA_W-1.

Timing and edge cases
- Total latency is 4 clk on vsync/href/clken/data; the post_* signals are a 4-stage shift of the inputs.
- clken with href low: ignored; no write, no count.
- vsync mid-line: counters clear and the border rule covers the next two rows.
- Reset mid-frame: outputs go to 0 immediately. The first two rows after reset are output as border pass-through, so stale RAM data is never used.

Optional Feature:
Macro MEAN_FILTER_ROUND_EN.
- Defined: RND16 = 32768, RND4 = 8, RND3 = 4 (round half up).
- Undefined: all RND terms are 0 (truncation); no other change in latency or area beyond the adders.

Test Plan:
- Flat frame 64x8 of value 100, mode 1 -> interior pixels 100; rows 0-1 and cols 0-1 output 100 (pass-through); post sync signals equal the inputs delayed exactly 4 clk.
- Single 255 impulse on 0 background, mode 1 -> the 9 surrounding outputs are 28 (both rounding variants); mode 2 -> centre 64 with ROUND_EN, 63 without.
- Neighbours 80, centre 0, mode 3 -> output 80; same window in mode 1 -> 71.
- mode switched from 1 to 0 mid-frame -> current frame stays box-filtered; next frame post_img_Y equals per_img_Y delayed (pass-through).
- Line of IMG_W+10 pixels -> pixels at and beyond col IMG_W-1 pass through unfiltered; no RAM address overflow (assertion on address < IMG_W).
- rst_n pulsed low for 3 clk mid-frame, then resumed -> outputs 0 during reset; first two rows after the next vsync pass through; filtering correct from row 2.
